// File: rtl/alu_pkg.sv
// Shared opcode map and flag-vector layout for the FORTH datapath ALU.
package alu_pkg;

    localparam logic [7:0] OP_PASSA  = 8'h00;
    localparam logic [7:0] OP_AND    = 8'h01;
    localparam logic [7:0] OP_OR     = 8'h02;
    localparam logic [7:0] OP_XOR    = 8'h03;
    localparam logic [7:0] OP_INVERT = 8'h04;
    localparam logic [7:0] OP_SHL    = 8'h05;
    localparam logic [7:0] OP_ASR    = 8'h06;
    localparam logic [7:0] OP_ADD    = 8'h07;
    localparam logic [7:0] OP_SUB    = 8'h08;
    localparam logic [7:0] OP_NEGATE = 8'h09;
    localparam logic [7:0] OP_INC    = 8'h0A;
    localparam logic [7:0] OP_DEC    = 8'h0B;
    localparam logic [7:0] OP_ZEQ    = 8'h0C;
    localparam logic [7:0] OP_ZLT    = 8'h0D;
    localparam logic [7:0] OP_EQ     = 8'h0E;
    localparam logic [7:0] OP_LT     = 8'h0F;
    localparam logic [7:0] OP_ULT    = 8'h10;
    localparam logic [7:0] OP_PASSB  = 8'h11;
    localparam logic [7:0] OP_RSHIFT = 8'h12;
    localparam logic [7:0] OP_UMSTAR = 8'h13;

    // Bit positions inside the registered flag vector.
    localparam int FLAG_C    = 0;
    localparam int FLAG_Z    = 1;
    localparam int FLAG_N    = 2;
    localparam int FLAG_V    = 3;
    localparam int NUM_FLAGS = 4;

endpackage

// File: rtl/alu_addsub.sv
// Shared WIDTH-bit adder/subtractor; carry is a borrow when sub=1.
module alu_addsub #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;
    logic             carry_out;

    assign b_eff = sub ? ~b : b;
    assign {carry_out, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

    // Two's-complement subtract yields carry_out=1 when no borrow occurred.
    assign carry    = carry_out ^ sub;
    assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_unit.sv
// Registered ALU with flag outputs for the FORTH CPU datapath.
// Optional macro ALU_MULT_EN enables opcode 13 (UM* low half).
module alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [7:0]       opcode,
    input  logic [WIDTH-1:0] oper0,
    input  logic [WIDTH-1:0] oper1,
    output logic [WIDTH-1:0] data_bus,
    output logic             flag_c,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v,
    output logic             illegal
);

    logic [WIDTH-1:0] as_a;
    logic [WIDTH-1:0] as_b;
    logic             as_sub;
    logic [WIDTH-1:0] as_sum;
    logic             as_carry;
    logic             as_ovf;

    logic [WIDTH-1:0]     next_result;
    logic                 next_c;
    logic                 next_v;
    logic                 next_illegal;
    logic [NUM_FLAGS-1:0] next_flags;

    logic [WIDTH-1:0]     result_q;
    logic [NUM_FLAGS-1:0] flags_q;
    logic                 illegal_q;

`ifdef ALU_MULT_EN
    logic [2*WIDTH-1:0] product;
    assign product = {{WIDTH{1'b0}}, oper0} * {{WIDTH{1'b0}}, oper1};
`endif

    // Steer the shared adder's operands for every op that needs it.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        as_a   = oper0;
        as_b   = oper1;
        as_sub = 1'b0;
        case (opcode)
            OP_SUB, OP_LT, OP_ULT: as_sub = 1'b1;
            OP_NEGATE: begin
                as_a   = '0;
                as_b   = oper0;
                as_sub = 1'b1;
            end
            OP_INC: as_b = WIDTH'(1);
            OP_DEC: begin
                as_b   = WIDTH'(1);
                as_sub = 1'b1;
            end
            default: ;
        endcase
    end

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a        (as_a),
        .b        (as_b),
        .sub      (as_sub),
        .sum      (as_sum),
        .carry    (as_carry),
        .overflow (as_ovf)
    );

    always_comb begin
        next_result  = '0;
        next_c       = 1'b0;
        next_v       = 1'b0;
        next_illegal = 1'b0;
        case (opcode)
            OP_PASSA:  next_result = oper0;
            OP_AND:    next_result = oper0 & oper1;
            OP_OR:     next_result = oper0 | oper1;
            OP_XOR:    next_result = oper0 ^ oper1;
            OP_INVERT: next_result = ~oper0;
            OP_SHL: begin
                next_result = {oper0[WIDTH-2:0], 1'b0};
                next_c      = oper0[WIDTH-1];
            end
            OP_ASR: begin
                next_result = {oper0[WIDTH-1], oper0[WIDTH-1:1]};
                next_c      = oper0[0];
            end
            OP_ADD, OP_SUB, OP_NEGATE, OP_INC, OP_DEC: begin
                next_result = as_sum;
                next_c      = as_carry;
                next_v      = as_ovf;
            end
            OP_ZEQ:    next_result = {WIDTH{oper0 == '0}};
            OP_ZLT:    next_result = {WIDTH{oper0[WIDTH-1]}};
            OP_EQ:     next_result = {WIDTH{oper0 == oper1}};
            // Signed less-than is the sign of A-B corrected by overflow.
            OP_LT:     next_result = {WIDTH{as_sum[WIDTH-1] ^ as_ovf}};
            OP_ULT:    next_result = {WIDTH{as_carry}};
            OP_PASSB:  next_result = oper1;
            OP_RSHIFT: begin
                next_result = {1'b0, oper0[WIDTH-1:1]};
                next_c      = oper0[0];
            end
`ifdef ALU_MULT_EN
            OP_UMSTAR: begin
                next_result = product[WIDTH-1:0];
                next_c      = |product[2*WIDTH-1:WIDTH];
            end
`endif
            default:   next_illegal = 1'b1;
        endcase
    end

    always_comb begin
        next_flags         = '0;
        next_flags[FLAG_C] = next_c;
        next_flags[FLAG_Z] = (next_result == '0);
        next_flags[FLAG_N] = next_result[WIDTH-1];
        next_flags[FLAG_V] = next_v;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q         <= '0;
            flags_q          <= '0;
            flags_q[FLAG_Z]  <= 1'b1;
            illegal_q        <= 1'b0;
        end else if (ena) begin
            // NOTE: state registers use non-blocking assignment so all of them update together.
            result_q  <= next_result;
            flags_q   <= next_flags;
            illegal_q <= next_illegal;
        end
    end

    assign data_bus = result_q;
    assign flag_c   = flags_q[FLAG_C];
    assign flag_z   = flags_q[FLAG_Z];
    assign flag_n   = flags_q[FLAG_N];
    assign flag_v   = flags_q[FLAG_V];
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed boundary steps plus random ops against an integer model.
module tb_alu_unit;

    typedef struct packed {
        logic [7:0] res;
        logic       c;
        logic       v;
        logic       ill;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] opcode;
    logic [7:0] oper0;
    logic [7:0] oper1;
    logic [7:0] data_bus;
    logic       flag_c, flag_z, flag_n, flag_v, illegal;

    int checks = 0;
    int errors = 0;

    alu_unit #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .opcode   (opcode),
        .oper0    (oper0),
        .oper1    (oper1),
        .data_bus (data_bus),
        .flag_c   (flag_c),
        .flag_z   (flag_z),
        .flag_n   (flag_n),
        .flag_v   (flag_v),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, ".data"}, {24'd0, data_bus}, {24'd0, e.res});
        check({tag, ".c"}, {31'd0, flag_c}, {31'd0, e.c});
        check({tag, ".z"}, {31'd0, flag_z}, {31'd0, (e.res == 8'h00)});
        check({tag, ".n"}, {31'd0, flag_n}, {31'd0, e.res[7]});
        check({tag, ".v"}, {31'd0, flag_v}, {31'd0, e.v});
        check({tag, ".ill"}, {31'd0, illegal}, {31'd0, e.ill});
    endtask

    // Behavioural model in plain integer arithmetic.
    function automatic exp_t model(input logic [7:0] opc, input logic [7:0] a, input logic [7:0] b);
        int   ua, ub, sa, sb, r, s;
        exp_t e;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        r = 0;
        e = '0;
        case (opc)
            8'h00: r = ua;
            8'h01: r = ua & ub;
            8'h02: r = ua | ub;
            8'h03: r = ua ^ ub;
            8'h04: r = 255 - ua;
            8'h05: begin r = ua * 2; e.c = (ua >= 128); end
            8'h06: begin r = sa >>> 1; e.c = (ua % 2 == 1); end
            8'h07: begin r = ua + ub; e.c = (r > 255); s = sa + sb; e.v = (s > 127) || (s < -128); end
            8'h08: begin r = ua - ub; e.c = (ua < ub); s = sa - sb; e.v = (s > 127) || (s < -128); end
            8'h09: begin r = 0 - ua; e.c = (ua > 0); e.v = (-sa > 127); end
            8'h0A: begin r = ua + 1; e.c = (r > 255); e.v = (sa + 1 > 127); end
            8'h0B: begin r = ua - 1; e.c = (ua < 1); e.v = (sa - 1 < -128); end
            8'h0C: r = (ua == 0) ? 255 : 0;
            8'h0D: r = (sa < 0) ? 255 : 0;
            8'h0E: r = (ua == ub) ? 255 : 0;
            8'h0F: r = (sa < sb) ? 255 : 0;
            8'h10: r = (ua < ub) ? 255 : 0;
            8'h11: r = ub;
            8'h12: begin r = ua / 2; e.c = (ua % 2 == 1); end
`ifdef ALU_MULT_EN
            8'h13: begin r = ua * ub; e.c = (r > 255); end
`endif
            default: begin r = 0; e.ill = 1'b1; end
        endcase
        e.res = r[7:0];
        return e;
    endfunction

    task automatic do_op(input logic [7:0] opc, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        opcode = opc;
        oper0  = a;
        oper1  = b;
        ena    = 1'b1;
        @(negedge clk);
        ena    = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [7:0] opc, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] res, input logic c,
                            input logic v, input logic ill);
        exp_t e;
        e.res = res;
        e.c   = c;
        e.v   = v;
        e.ill = ill;
        do_op(opc, a, b);
        check_outputs(tag, e);
    endtask

    initial begin
        exp_t prev;
        exp_t cur;
        logic [7:0] r_opc, r_a, r_b;

        rst    = 1'b1;
        ena    = 1'b0;
        opcode = 8'h00;
        oper0  = 8'h00;
        oper1  = 8'h00;
        #23;
        rst = 1'b0;
        @(negedge clk);
        check_outputs("reset", '{res: 8'h00, c: 1'b0, v: 1'b0, ill: 1'b0});

        // Single capture then hold while inputs move.
        do_op(8'h07, 8'h02, 8'h03);
        check_outputs("add_2_3", '{res: 8'h05, c: 1'b0, v: 1'b0, ill: 1'b0});
        oper0  = 8'hAA;
        oper1  = 8'h55;
        opcode = 8'h03;
        repeat (10) @(negedge clk);
        check_outputs("hold", '{res: 8'h05, c: 1'b0, v: 1'b0, ill: 1'b0});

        directed("add_ff_01", 8'h07, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
        directed("add_7f_01", 8'h07, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
        directed("sub_00_01", 8'h08, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0);
        directed("neg_80",    8'h09, 8'h80, 8'h00, 8'h80, 1'b1, 1'b1, 1'b0);
        directed("and",       8'h01, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
        directed("xor",       8'h03, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0, 1'b0);
        directed("invert",    8'h04, 8'h0F, 8'h00, 8'hF0, 1'b0, 1'b0, 1'b0);
        directed("shl_81",    8'h05, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0);
        directed("asr_81",    8'h06, 8'h81, 8'h00, 8'hC0, 1'b1, 1'b0, 1'b0);
        directed("asr_80",    8'h06, 8'h80, 8'h00, 8'hC0, 1'b0, 1'b0, 1'b0);
        directed("rshift_81", 8'h12, 8'h81, 8'h00, 8'h40, 1'b1, 1'b0, 1'b0);
        directed("inc_ff",    8'h0A, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        directed("dec_80",    8'h0B, 8'h80, 8'h00, 8'h7F, 1'b0, 1'b1, 1'b0);
        directed("zeq_00",    8'h0C, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
        directed("eq_12",     8'h0E, 8'h12, 8'h12, 8'hFF, 1'b0, 1'b0, 1'b0);
        directed("lt_80_01",  8'h0F, 8'h80, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0);
        directed("ult_80_01", 8'h10, 8'h80, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
        directed("passb",     8'h11, 8'h11, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0);
        directed("illegal3f", 8'h3F, 8'h12, 8'h34, 8'h00, 1'b0, 1'b0, 1'b1);
        directed("clear_ill", 8'h07, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
`ifdef ALU_MULT_EN
        directed("umstar",    8'h13, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0);
`else
        directed("op13_ill",  8'h13, 8'h10, 8'h10, 8'h00, 1'b0, 1'b0, 1'b1);
`endif

        // Asynchronous reset clears outputs without a clock edge.
        do_op(8'h00, 8'h9C, 8'h00);
        check_outputs("pre_rst", '{res: 8'h9C, c: 1'b0, v: 1'b0, ill: 1'b0});
        #2;
        rst = 1'b1;
        #1;
        check_outputs("async_rst", '{res: 8'h00, c: 1'b0, v: 1'b0, ill: 1'b0});

        // An operation presented while reset is held is discarded.
        @(negedge clk);
        opcode = 8'h07;
        oper0  = 8'h40;
        oper1  = 8'h40;
        ena    = 1'b1;
        @(negedge clk);
        ena = 1'b0;
        rst = 1'b0;
        check_outputs("rst_discard", '{res: 8'h00, c: 1'b0, v: 1'b0, ill: 1'b0});
        @(negedge clk);
        check_outputs("rst_release", '{res: 8'h00, c: 1'b0, v: 1'b0, ill: 1'b0});

        // Random stream: back-to-back enables mixed with idle (hold) cycles.
        prev = '{res: 8'h00, c: 1'b0, v: 1'b0, ill: 1'b0};
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (i > 0) check_outputs("rand", prev);
            r_opc = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 20));
            r_a   = 8'($urandom);
            r_b   = 8'($urandom);
            opcode = r_opc;
            oper0  = r_a;
            oper1  = r_b;
            ena    = ($urandom_range(0, 3) != 0);
            if (ena) begin
                cur  = model(r_opc, r_a, r_b);
                prev = cur;
            end
        end
        @(negedge clk);
        ena = 1'b0;
        check_outputs("rand_last", prev);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
